// File: rtl/ex_alu_sequencer.sv
// Execute-stage sequencer: single-cycle ALU ops, held MUL, iterative restoring DIV,
// plus the persistent flags register read by BRFL.
module ex_alu_sequencer #(
   parameter int unsigned MUL_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  alu_control,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        flags_clear,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        zero,
   output logic [4:0]  flags,
   output logic        busy
);

   localparam logic [4:0] OpLw1 = 5'h00, OpLw2 = 5'h01, OpLw3 = 5'h02, OpSw1 = 5'h03;
   localparam logic [4:0] OpSw2 = 5'h04, OpMov = 5'h05, OpAdd = 5'h06, OpSub = 5'h07;
   localparam logic [4:0] OpMul = 5'h08, OpDiv = 5'h09, OpAnd = 5'h0a, OpOr  = 5'h0b;
   localparam logic [4:0] OpNot = 5'h0c, OpShl = 5'h0d, OpShr = 5'h0e, OpCmp = 5'h0f;
   localparam logic [4:0] OpJr  = 5'h10, OpJpc = 5'h11, OpBrfl = 5'h12, OpCall = 5'h13;

   typedef enum logic [1:0] {StIdle, StMulWait, StDivRun, StDivFix} state_e;

   state_e      state_q, state_d;
   logic [4:0]  op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] result_q, result_d;
   logic        zero_q, zero_d;
   logic [4:0]  flags_q, flags_d;

   logic        accept, out_free;
   logic [4:0]  op_sel;
   logic [31:0] a_sel, b_sel;
   logic [31:0] sum, diff;
   logic [63:0] prod;
   logic        add_ovf, sub_ovf, mul_ovf, div_zero, div_ovf, div_special;
   logic [31:0] alu_res;
   logic [4:0]  alu_flags;
   logic        alu_wr_flags, alu_zero_en, alu_zero, brfl_hit;

   logic [32:0] div_shift, div_trial;
   logic        div_ge, div_neg;
   logic [31:0] rem_nxt, quot_nxt, div_src, div_fixed;

   logic        ld, ld_zero, ld_wr;
   logic [31:0] ld_res;
   logic [4:0]  ld_flags;

   assign out_free  = !out_valid_q || out_ready;
   assign in_ready  = (state_q == StIdle) && out_free;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign flags     = flags_q;
   assign busy      = (state_q != StIdle);

   // Captured operands feed the shared ALU once a multi-cycle op is in flight.
   assign op_sel = (state_q == StIdle) ? alu_control : op_q;
   assign a_sel  = (state_q == StIdle) ? op_a : a_q;
   assign b_sel  = (state_q == StIdle) ? op_b : b_q;

   assign sum         = a_sel + b_sel;
   assign diff        = a_sel - b_sel;
   assign prod        = 64'($signed(a_sel)) * 64'($signed(b_sel));
   assign add_ovf     = (a_sel[31] == b_sel[31]) && (sum[31] != a_sel[31]);
   assign sub_ovf     = (a_sel[31] != b_sel[31]) && (diff[31] != a_sel[31]);
   assign mul_ovf     = (prod[63:32] != {32{prod[31]}});
   assign div_zero    = (b_sel == 32'd0);
   assign div_ovf     = (a_sel == 32'h8000_0000) && (b_sel == 32'hffff_ffff);
   assign div_special = div_zero || div_ovf;

   always_comb begin
      alu_res      = '0;
      alu_flags    = '0;
      alu_wr_flags = 1'b0;
      alu_zero_en  = 1'b0;
      brfl_hit     = 1'b0;
      case (op_sel)
         OpLw1, OpSw1:                      alu_res = a_sel + 32'd8;
         OpLw2, OpLw3, OpSw2, OpJr, OpCall: alu_res = a_sel;
         OpMov: alu_res = {22'b0, a_sel[4:0], b_sel[4:0]};
         OpAdd: begin
            alu_res      = sum;
            alu_zero_en  = 1'b1;
            alu_wr_flags = 1'b1;
            alu_flags    = {add_ovf, 3'b000, add_ovf};
         end
         OpSub: begin
            alu_res      = diff;
            alu_zero_en  = 1'b1;
            alu_wr_flags = 1'b1;
            alu_flags    = {sub_ovf, 3'b000, sub_ovf};
         end
         OpMul: begin
            alu_res      = prod[31:0];
            alu_zero_en  = 1'b1;
            alu_wr_flags = 1'b1;
            alu_flags    = {mul_ovf, 3'b000, mul_ovf};
         end
         OpDiv: begin
            // Only the one-cycle special cases resolve here.
            alu_zero_en  = 1'b1;
            alu_wr_flags = 1'b1;
            if (div_zero) begin
               alu_flags = 5'b10000;
            end else if (div_ovf) begin
               alu_res   = 32'h8000_0000;
               alu_flags = 5'b10001;
            end
         end
         OpAnd: begin
            alu_res     = a_sel & b_sel;
            alu_zero_en = 1'b1;
         end
         OpOr: begin
            alu_res     = a_sel | b_sel;
            alu_zero_en = 1'b1;
         end
         OpNot: alu_res = ~a_sel;
         OpShl: alu_res = a_sel << b_sel[4:0];
         OpShr: alu_res = a_sel >> b_sel[4:0];
         OpCmp: begin
            alu_wr_flags = 1'b1;
            alu_flags    = {1'b0, a_sel == b_sel, $signed(a_sel) < $signed(b_sel),
                            $signed(a_sel) > $signed(b_sel), 1'b0};
         end
         OpJpc: alu_res = sum;
         OpBrfl: begin
            brfl_hit = (flags_q == b_sel[4:0]);
            alu_res  = brfl_hit ? a_sel : 32'd0;
         end
         default: ;
      endcase
      alu_zero = alu_zero_en ? (alu_res == 32'd0) : brfl_hit;
   end

   // One restoring step on magnitudes; remainder always stays below the divisor.
   assign div_shift = {rem_q, quot_q[31]};
   assign div_trial = div_shift - {1'b0, dvsr_q};
   assign div_ge    = !div_trial[32];
   assign rem_nxt   = div_ge ? div_trial[31:0] : div_shift[31:0];
   assign quot_nxt  = {quot_q[30:0], div_ge};
   assign div_neg   = a_q[31] ^ b_q[31];
   assign div_src   = (state_q == StDivFix) ? quot_q : quot_nxt;
   assign div_fixed = div_neg ? -div_src : div_src;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      dvsr_d   = dvsr_q;
      ld       = 1'b0;
      ld_res   = alu_res;
      ld_zero  = alu_zero;
      ld_flags = alu_flags;
      ld_wr    = alu_wr_flags;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               op_d = alu_control;
               a_d  = op_a;
               b_d  = op_b;
               if (alu_control == OpMul && MUL_CYCLES > 1) begin
                  state_d = StMulWait;
                  cnt_d   = 5'(MUL_CYCLES - 1);
               end else if (alu_control == OpDiv && !div_special) begin
                  state_d = StDivRun;
                  cnt_d   = 5'd31;
                  quot_d  = op_a[31] ? -op_a : op_a;
                  dvsr_d  = op_b[31] ? -op_b : op_b;
                  rem_d   = '0;
               end else begin
                  ld = 1'b1;
               end
            end
         end
         StMulWait: begin
            // Completes on the edge the counter reaches zero, or later if output is held.
            if (cnt_q <= 5'd1) begin
               cnt_d = '0;
               if (out_free) begin
                  ld      = 1'b1;
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         StDivRun: begin
            quot_d = quot_nxt;
            rem_d  = rem_nxt;
            cnt_d  = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               cnt_d    = '0;
               ld_res   = div_fixed;
               ld_zero  = (div_fixed == 32'd0);
               ld_flags = '0;
               ld_wr    = 1'b1;
               if (out_free) begin
                  ld      = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StDivFix;
               end
            end
         end
         StDivFix: begin
            ld_res   = div_fixed;
            ld_zero  = (div_fixed == 32'd0);
            ld_flags = '0;
            ld_wr    = 1'b1;
            if (out_free) begin
               ld      = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A completing flag-writing op overrides a same-edge clear.
      flags_d     = flags_clear ? 5'd0 : flags_q;
      out_valid_d = out_valid_q && !out_ready;
      result_d    = result_q;
      zero_d      = zero_q;
      if (ld) begin
         out_valid_d = 1'b1;
         result_d    = ld_res;
         zero_d      = ld_zero;
         if (ld_wr) begin
            flags_d = ld_flags;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         quot_q      <= '0;
         rem_q       <= '0;
         dvsr_q      <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         dvsr_q      <= dvsr_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         flags_q     <= flags_d;
      end
   end

endmodule

// File: tb/tb_ex_alu_sequencer.sv
// Directed bench for ex_alu_sequencer: vector table for single-cycle ops plus
// hand sequences for MUL/DIV latency, backpressure, flag clearing and reset.
module tb_ex_alu_sequencer;

   localparam int unsigned MulCycles = 3;

   localparam logic [4:0] OpLw1 = 5'h00, OpSw2 = 5'h04, OpMov = 5'h05, OpAdd = 5'h06;
   localparam logic [4:0] OpSub = 5'h07, OpMul = 5'h08, OpDiv = 5'h09, OpAnd = 5'h0a;
   localparam logic [4:0] OpOr  = 5'h0b, OpNot = 5'h0c, OpShl = 5'h0d, OpShr = 5'h0e;
   localparam logic [4:0] OpCmp = 5'h0f, OpJpc = 5'h11, OpBrfl = 5'h12, OpRet = 5'h14;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, flags_clear, out_valid, out_ready, zero, busy;
   logic [4:0]  alu_control, flags;
   logic [31:0] op_a, op_b, result;

   ex_alu_sequencer #(.MUL_CYCLES(MulCycles)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_control(alu_control),
      .op_a       (op_a),
      .op_b       (op_b),
      .flags_clear(flags_clear),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .zero       (zero),
      .flags      (flags),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic [4:0]  fl;
   } vec_t;

   vec_t vecs [21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_multi(input string name, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                            input logic exp_z, input logic [4:0] exp_fl);
      int lat;
      int busy_low;
      @(negedge clk);
      in_valid = 1'b1; alu_control = op; op_a = a; op_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = 1;
      busy_low = 0;
      while (!out_valid && lat < 60) begin
         if (!busy) busy_low++;
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("%s latency", name), 32'(lat), 32'(exp_lat));
      chk($sformatf("%s busy-gaps", name), 32'(busy_low), 32'd0);
      chk($sformatf("%s busy-done", name), 32'(busy), 32'd0);
      chk($sformatf("%s result", name), result, exp_res);
      chk($sformatf("%s zero", name), 32'(zero), 32'(exp_z));
      chk($sformatf("%s flags", name), 32'(flags), 32'(exp_fl));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{OpAdd,  32'd5,          32'd7,          32'd12,         1'b0, 5'h00};
      vecs[1]  = '{OpSub,  32'd5,          32'd5,          32'd0,          1'b1, 5'h00};
      vecs[2]  = '{OpAdd,  32'h7fff_ffff,  32'd1,          32'h8000_0000,  1'b0, 5'h11};
      vecs[3]  = '{OpBrfl, 32'h40,         32'h11,         32'h40,         1'b1, 5'h11};
      vecs[4]  = '{OpBrfl, 32'h40,         32'h01,         32'd0,          1'b0, 5'h11};
      vecs[5]  = '{OpMov,  32'h123,        32'h3e,         32'h7e,         1'b0, 5'h11};
      vecs[6]  = '{OpAdd,  32'hffff_ffff,  32'd1,          32'd0,          1'b1, 5'h00};
      vecs[7]  = '{OpSub,  32'h8000_0000,  32'd1,          32'h7fff_ffff,  1'b0, 5'h11};
      vecs[8]  = '{OpLw1,  32'h100,        32'd0,          32'h108,        1'b0, 5'h11};
      vecs[9]  = '{OpSw2,  32'hdead_beef,  32'd5,          32'hdead_beef,  1'b0, 5'h11};
      vecs[10] = '{OpNot,  32'h0f0f_0f0f,  32'd0,          32'hf0f0_f0f0,  1'b0, 5'h11};
      vecs[11] = '{OpOr,   32'd0,          32'd0,          32'd0,          1'b1, 5'h11};
      vecs[12] = '{OpShr,  32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 5'h11};
      vecs[13] = '{OpCmp,  32'd9,          32'd3,          32'd0,          1'b0, 5'h02};
      vecs[14] = '{OpCmp,  32'hffff_ffff,  32'd2,          32'd0,          1'b0, 5'h04};
      vecs[15] = '{OpJpc,  32'h1000,       32'hffff_fffc,  32'hffc,        1'b0, 5'h04};
      vecs[16] = '{OpRet,  32'd5,          32'd6,          32'd0,          1'b0, 5'h04};
      vecs[17] = '{5'h1f,  32'd5,          32'd6,          32'd0,          1'b0, 5'h04};
      vecs[18] = '{OpShl,  32'd1,          32'h3f,         32'h8000_0000,  1'b0, 5'h04};
      vecs[19] = '{OpAnd,  32'hffff_0000,  32'h0000_ffff,  32'd0,          1'b1, 5'h04};
      vecs[20] = '{OpBrfl, 32'h77,         32'h04,         32'h77,         1'b1, 5'h04};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flags_clear = 1'b0;
      alu_control = '0; op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset flags", 32'(flags), 32'd0);
      chk("reset result", result, 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         in_valid = 1'b1; alu_control = vecs[i].op; op_a = vecs[i].a; op_b = vecs[i].b;
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d result", i), result, vecs[i].res);
         chk($sformatf("vec%0d zero", i), 32'(zero), 32'(vecs[i].z));
         chk($sformatf("vec%0d flags", i), 32'(flags), 32'(vecs[i].fl));
      end

      // Back-to-back: AND, SHL, then CMP completing together with flags_clear.
      @(negedge clk);
      in_valid = 1'b1; alu_control = OpAnd; op_a = 32'hf0; op_b = 32'h0f;
      @(posedge clk);
      @(negedge clk);
      chk("b2b and result", result, 32'd0);
      chk("b2b and zero", 32'(zero), 32'd1);
      chk("b2b shl ready", 32'(in_ready), 32'd1);
      alu_control = OpShl; op_a = 32'd1; op_b = 32'd31;
      @(posedge clk);
      @(negedge clk);
      chk("b2b shl result", result, 32'h8000_0000);
      chk("b2b shl valid", 32'(out_valid), 32'd1);
      alu_control = OpCmp; op_a = 32'd4; op_b = 32'd4; flags_clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; flags_clear = 1'b0;
      chk("b2b cmp beats clear", 32'(flags), 32'h08);
      chk("b2b cmp result", result, 32'd0);
      flags_clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flags_clear = 1'b0;
      chk("clear alone", 32'(flags), 32'd0);

      run_multi("mul ovf", OpMul, 32'h0001_0000, 32'h0001_0000, 3, 32'd0, 1'b1, 5'h11);
      run_multi("mul neg", OpMul, 32'hffff_fffd, 32'd5, 3, 32'hffff_fff1, 1'b0, 5'h00);

      // Backpressure: CMP result held while downstream stalls.
      @(negedge clk);
      in_valid = 1'b1; alu_control = OpCmp; op_a = 32'd3; op_b = 32'd9;
      @(posedge clk); #1;
      out_ready = 1'b0;
      alu_control = OpAdd; op_a = 32'd1; op_b = 32'd1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("hold%0d valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("hold%0d result", k), result, 32'd0);
         chk($sformatf("hold%0d flags", k), 32'(flags), 32'h04);
         chk($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("release in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("release add result", result, 32'd2);
      chk("release add flags", 32'(flags), 32'd0);

      run_multi("div neg", OpDiv, 32'hffff_ff9c, 32'd7, 33, 32'hffff_fff2, 1'b0, 5'h00);
      run_multi("div big", OpDiv, 32'h7fff_ffff, 32'd3, 33, 32'h2aaa_aaaa, 1'b0, 5'h00);
      run_multi("div zero", OpDiv, 32'd5, 32'd0, 1, 32'd0, 1'b1, 5'h10);
      run_multi("div ovf", OpDiv, 32'h8000_0000, 32'hffff_ffff, 1, 32'h8000_0000, 1'b0, 5'h11);

      // Reset in the middle of a divide.
      @(negedge clk);
      in_valid = 1'b1; alu_control = OpDiv; op_a = 32'd100; op_b = 32'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("mid-div busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst-div out_valid", 32'(out_valid), 32'd0);
      chk("rst-div busy", 32'(busy), 32'd0);
      chk("rst-div flags", 32'(flags), 32'd0);
      chk("rst-div result", result, 32'd0);
      run_multi("post-rst add", OpAdd, 32'd1, 32'd1, 1, 32'd2, 1'b0, 5'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_alu_sequencer.md
# ex_alu_sequencer

Execute-stage sequencer for the 32-bit ALU operation set (5-bit ALUControl encoding: LW_1=0x00 … NOP=0x15). It accepts one operation at a time from the ID/EX register through a valid/ready handshake. Single-cycle operations complete in one cycle; MUL is held for a configurable number of cycles; DIV runs on an iterative 32-step restoring divider. It owns the persistent 5-bit flags register consumed by BRFL and stalls the pipeline (`busy`) while a multi-cycle operation is in flight.

## Interface
- MUL_CYCLES, default 3: cycles from accept to result for MUL; legal range 1..15.
- clk  in  1  rising-edge clock; one clock domain.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  combinational: state==IDLE && (!out_valid || out_ready).
- alu_control  in  5  opcode, ALUControl encoding.
- op_a, op_b  in  32  signed operands (data1, data2).
- flags_clear  in  1  synchronous clear of the flags register.
- out_valid  out  1  result available.
- out_ready  in  1  downstream (MEM) accepts the result.
- result  out  32  ALUResult.
- zero  out  1  zero/branch-taken indication.
- flags  out  5  [4] error, [3] equal, [2] below, [1] above, [0] overflow.
- busy  out  1  state != IDLE.

## Operation
- Accept occurs when in_valid && in_ready. Operands and opcode are captured on that edge.
- States:
  - IDLE.
  - MUL_WAIT: counter loaded with MUL_CYCLES-1; exits at 0.
  - DIV_RUN: 32 iterations; quotient/remainder on the magnitudes.
  - DIV_FIX: apply the quotient sign, write the output.
- Entry to the multi-cycle states:
  - MUL with MUL_CYCLES=1 completes like a single-cycle operation.
  - DIV with op_b==0 or (op_a==0x80000000 && op_b==-1) completes in one cycle and never enters DIV_RUN.
- Results; all arithmetic is signed 32-bit and wraps modulo 2^32:
  - LW_1, SW_1: a+8.
  - LW_2, LW_3, SW_2, JR, CALL: a.
  - MOV: {22'b0, a[4:0], b[4:0]}.
  - ADD: a+b. SUB: a−b. JPC: a+b.
  - MUL: low 32 bits of the 64-bit signed product.
  - DIV: quotient truncated toward zero. Divide by zero gives 0. 0x80000000/−1 gives 0x80000000.
  - AND, OR, NOT: bitwise.
  - SHL, SHR: logical shift of a by b[4:0].
  - CMP, RET, NOP, undefined opcodes: result 0.
  - BRFL: a if flags==b[4:0], else 0.
- zero:
  - ADD, SUB, MUL, DIV, AND, OR: (result==0).
  - BRFL: 1 on match, else 0.
  - All other opcodes: 0.
- Flags register:
  - Written only on completion of ADD, SUB, MUL, DIV, CMP. The full 5-bit vector is replaced. All other ops leave it unchanged.
  - ADD/SUB overflow: the standard two's-complement sign rule. Sets [0] and [4].
  - MUL overflow: product[63:32] != {32{product[31]}}. Sets [0] and [4].
  - DIV by zero: sets [4] only. 0x80000000/−1: sets [0] and [4].
  - CMP: signed compare; exactly one of [3] equal, [1] above (a>b), [2] below is set.
- flags_clear zeroes the register. If a flag-writing op completes on the same edge, the op's flags win.
- BRFL compares against the register value before any same-cycle update.

## Timing
- Reset, synchronous and overriding everything else:
  - state=IDLE; out_valid, result, zero, flags, busy = 0.
  - Any in-flight MUL/DIV is discarded.
  - in_ready=1 from the first cycle after reset deasserts.
- Latency, counted from the accept edge to out_valid high:
  - 1 cycle: single-cycle ops, DIV special cases, MUL with MUL_CYCLES=1.
  - MUL_CYCLES cycles: MUL.
  - 33 cycles: DIV (32 in DIV_RUN, 1 in DIV_FIX).
- Throughput: one single-cycle op per clock when out_ready stays high.
- Output hold: while out_valid && !out_ready, result, zero and flags stay stable and in_ready=0.
  - A multi-cycle op that finishes while the previous result is unconsumed waits in its final state until out_ready.
- out_valid falls on the edge where out_ready is sampled high, unless a new result loads on that same edge.
- busy is high from the edge after a MUL/DIV accept until the edge that asserts its out_valid.
- Inputs are ignored while busy.

## Test plan
- Reset mid-DIV: accept DIV 100/7, assert reset at cycle 10 -> next cycle out_valid=0, busy=0, flags=0. A new ADD 1+1 accepted afterwards returns 2 after 1 cycle.
- ADD overflow: 0x7FFFFFFF + 1 -> after 1 cycle result=0x80000000, zero=0, flags=5'b10001. Then BRFL a=0x40, b=5'b10001 -> result=0x40, zero=1.
- DIV: −100/7 -> result=−14, out_valid exactly 33 cycles after accept, busy high for those cycles.
  - Then 5/0 -> result=0, flags=5'b10000, latency 1.
  - Then 0x80000000/−1 -> result=0x80000000, flags=5'b10001.
- MUL with MUL_CYCLES=3: 0x10000 × 0x10000 -> result=0, zero=1, flags=5'b10001, out_valid 3 cycles after accept. −3 × 5 -> −15, flags=0.
- Backpressure: hold out_ready=0 after CMP 3,9 completes -> result=0 and flags=5'b00100 stable for 5 cycles, in_ready=0. Release -> the next op is accepted the same cycle.
- Back-to-back single-cycle ops with out_ready=1: AND 0xF0&0x0F, SHL 1<<31, flags_clear coincident with CMP 4,4 completing -> results 0 (zero=1) and 0x80000000 on consecutive cycles; flags=5'b01000, because the CMP result wins over flags_clear.
